// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the clock divider array.
package clkdiv_pkg;

  // Output shaping of a channel: 50% square wave, or a one-cycle pulse per period.
  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  // Reset divisor: 50 MHz clkin down to a 1 kHz clkout in TOGGLE mode.
  localparam int unsigned CLKDIV_DEF_DIV = 25000;

  // Channel selector width; bounds the number of channels that can be addressed.
  localparam int unsigned CFG_CH_W     = 4;
  localparam int unsigned CLKDIV_MAX_CH = 16;

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: active and pending configuration, period counter,
// and registered clkout/tick outputs.
//
// Config handshake: cfg_we is a single-cycle strobe with no back-pressure.
// The strobe is always accepted. It is committed directly to the active
// configuration when this edge is an activation point: a clear, a frozen
// channel, or a period boundary. At a boundary the old settings finish that
// period and the new ones govern the next one. Otherwise the strobe is parked
// in the pending slot, and a later strobe overwrites it.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int unsigned CW      = 32,
  parameter int unsigned DEF_DIV = CLKDIV_DEF_DIV
) (
  input  logic          clkin,
  input  logic          rst,
  input  logic          clken,
  input  logic          ch_clr,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_div,
  input  logic          cfg_mode,
  output logic          clkout,
  output logic          tick
);

  localparam logic [CW-1:0] RST_DIV = CW'(DEF_DIV);

  // Registered state
  logic [CW-1:0] r_act_div;
  mode_e         r_act_mode;
  logic [CW-1:0] r_pend_div;
  mode_e         r_pend_mode;
  logic          r_pend_vld;
  logic [CW-1:0] r_cnt;
  logic          r_clkout;
  logic          r_tick;

  // Next-state values
  logic [CW-1:0] w_act_div_nxt;
  mode_e         w_act_mode_nxt;
  logic [CW-1:0] w_pend_div_nxt;
  mode_e         w_pend_mode_nxt;
  logic          w_pend_vld_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_clkout_nxt;
  logic          w_tick_nxt;

  // Decoded conditions
  mode_e         w_cfg_mode;
  logic [CW-1:0] w_last;
  logic          w_div_zero;
  logic          w_frozen;
  logic          w_boundary;
  logic          w_apply;

  // Classify this edge: frozen channel, period boundary, or activation point.
  always_comb begin
    w_cfg_mode = mode_e'(cfg_mode);
    w_div_zero = (r_act_div == '0);
    w_last     = r_act_div - CW'(1);
    w_frozen   = !clken || w_div_zero;
    // A count already beyond the last position (left over from a smaller
    // divisor loaded while the channel was paused) closes the period at once
    // rather than running the counter around its full range.
    w_boundary = !ch_clr && clken && !w_div_zero && (r_cnt >= w_last);
    w_apply    = ch_clr || w_frozen || w_boundary;
  end

  // Counter and output shaping; the boundary uses the configuration in force now.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_clkout_nxt = r_clkout;
    w_tick_nxt   = 1'b0;
    if (ch_clr || w_div_zero) begin
      w_cnt_nxt    = '0;
      w_clkout_nxt = 1'b0;
    end else if (!clken) begin
      w_cnt_nxt    = r_cnt;
      w_clkout_nxt = r_clkout;
    end else if (w_boundary) begin
      w_cnt_nxt    = '0;
      w_tick_nxt   = 1'b1;
      w_clkout_nxt = (r_act_mode == MODE_TOGGLE) ? ~r_clkout : 1'b1;
    end else begin
      w_cnt_nxt    = r_cnt + CW'(1);
      w_clkout_nxt = (r_act_mode == MODE_TOGGLE) ? r_clkout : 1'b0;
    end
  end

  // Config pipeline: a fresh write wins over an older pending one.
  always_comb begin
    w_act_div_nxt   = r_act_div;
    w_act_mode_nxt  = r_act_mode;
    w_pend_div_nxt  = r_pend_div;
    w_pend_mode_nxt = r_pend_mode;
    w_pend_vld_nxt  = r_pend_vld;
    if (w_apply) begin
      if (cfg_we) begin
        w_act_div_nxt  = cfg_div;
        w_act_mode_nxt = w_cfg_mode;
      end else if (r_pend_vld) begin
        w_act_div_nxt  = r_pend_div;
        w_act_mode_nxt = r_pend_mode;
      end
      w_pend_vld_nxt = 1'b0;
    end else if (cfg_we) begin
      w_pend_div_nxt  = cfg_div;
      w_pend_mode_nxt = w_cfg_mode;
      w_pend_vld_nxt  = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clkin) begin
    if (!rst) begin
      r_act_div   <= RST_DIV;
      r_act_mode  <= MODE_TOGGLE;
      r_pend_div  <= RST_DIV;
      r_pend_mode <= MODE_TOGGLE;
      r_pend_vld  <= 1'b0;
      r_cnt       <= '0;
      r_clkout    <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_act_div   <= w_act_div_nxt;
      r_act_mode  <= w_act_mode_nxt;
      r_pend_div  <= w_pend_div_nxt;
      r_pend_mode <= w_pend_mode_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_cnt       <= w_cnt_nxt;
      r_clkout    <= w_clkout_nxt;
      r_tick      <= w_tick_nxt;
    end
  end

  assign clkout = r_clkout;
  assign tick   = r_tick;

endmodule

// File: rtl/clkdiv_array.sv
// Array of NCH independent clock dividers sharing one config write port.
module clkdiv_array
  import clkdiv_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CW      = 32,
  parameter int unsigned DEF_DIV = CLKDIV_DEF_DIV
) (
  input  logic                clkin,
  input  logic                rst,
  input  logic [NCH-1:0]      clken,
  input  logic [NCH-1:0]      ch_clr,
  input  logic                cfg_we,
  input  logic [CFG_CH_W-1:0] cfg_ch,
  input  logic [CW-1:0]       cfg_div,
  input  logic                cfg_mode,
  output logic [NCH-1:0]      clkout,
  output logic [NCH-1:0]      tick
);

  // Per-channel write strobes; a selector at or above NCH matches no channel.
  logic [NCH-1:0] w_we;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign w_we[gi] = cfg_we && (cfg_ch == CFG_CH_W'(gi));

    clkdiv_chan #(
      .CW      (CW),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clkin    (clkin),
      .rst      (rst),
      .clken    (clken[gi]),
      .ch_clr   (ch_clr[gi]),
      .cfg_we   (w_we[gi]),
      .cfg_div  (cfg_div),
      .cfg_mode (cfg_mode),
      .clkout   (clkout[gi]),
      .tick     (tick[gi])
    );
  end

endmodule

// File: tb/tb_clkdiv_array.sv
// Self-checking bench for clkdiv_array: directed table, corner sequences,
// and randomized traffic against a cycle-level reference model.
`timescale 1ns/1ps
module tb_clkdiv_array;
  import clkdiv_pkg::*;

  localparam int NCH     = 4;
  localparam int CW      = 16;
  localparam int DEF_DIV = 4;

  // ---------------- clock / reset / DUT ----------------
  logic           clkin = 1'b0;
  logic           rst;
  logic [NCH-1:0] clken;
  logic [NCH-1:0] ch_clr;
  logic           cfg_we;
  logic [3:0]     cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic           cfg_mode;
  logic [NCH-1:0] clkout;
  logic [NCH-1:0] tick;

  always #5 clkin = ~clkin;

  clkdiv_array #(
    .NCH     (NCH),
    .CW      (CW),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clkin    (clkin),
    .rst      (rst),
    .clken    (clken),
    .ch_clr   (ch_clr),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_mode (cfg_mode),
    .clkout   (clkout),
    .tick     (tick)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- scoreboard ----------------
  logic [2*NCH-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each channel is described by its divisor, mode, a parked write, and the
  // number of enabled cycles already spent in the current period.
  int m_div   [NCH];
  int m_mode  [NCH];
  int m_pdiv  [NCH];
  int m_pmode [NCH];
  bit m_pvld  [NCH];
  int m_pos   [NCH];
  bit m_out   [NCH];
  bit m_tk    [NCH];

  task automatic model_step();
    logic [2*NCH-1:0] e;
    bit wr, running, ends;
    for (int c = 0; c < NCH; c++) begin
      wr = cfg_we && (int'(cfg_ch) == c);
      if (!rst) begin
        m_div[c] = DEF_DIV; m_mode[c] = 0; m_pvld[c] = 0;
        m_pos[c] = 0; m_out[c] = 0; m_tk[c] = 0;
      end else begin
        running = clken[c] && (m_div[c] > 0);
        ends    = running && !ch_clr[c] && (m_pos[c] + 1 >= m_div[c]);
        // outputs, judged with the settings that were in force
        if (ch_clr[c] || m_div[c] == 0) begin
          m_pos[c] = 0; m_out[c] = 0; m_tk[c] = 0;
        end else if (!clken[c]) begin
          m_tk[c] = 0;
        end else if (ends) begin
          m_pos[c] = 0;
          m_tk[c]  = 1;
          m_out[c] = (m_mode[c] == 1) ? 1'b1 : !m_out[c];
        end else begin
          m_pos[c] = m_pos[c] + 1;
          m_tk[c]  = 0;
          if (m_mode[c] == 1) m_out[c] = 0;
        end
        // configuration takes effect on clear, while frozen, or at period end
        if (ch_clr[c] || !running || ends) begin
          if (wr) begin
            m_div[c] = int'(cfg_div); m_mode[c] = int'(cfg_mode);
          end else if (m_pvld[c]) begin
            m_div[c] = m_pdiv[c]; m_mode[c] = m_pmode[c];
          end
          m_pvld[c] = 0;
        end else if (wr) begin
          m_pdiv[c] = int'(cfg_div); m_pmode[c] = int'(cfg_mode); m_pvld[c] = 1;
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      e[NCH + c] = m_out[c];
      e[c]       = m_tk[c];
    end
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clkin);
    model_step();
  end

  initial forever begin
    logic [2*NCH-1:0] e;
    @(negedge clkin);
    if (exp_q.size() == 0) begin
      chk("model_queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("model_clkout_tick", {24'd0, clkout, tick}, {24'd0, e});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [NCH-1:0] en, input logic [NCH-1:0] clr, input logic we,
                       input logic [3:0] ch, input logic [CW-1:0] dv, input logic md);
    clken = en; ch_clr = clr; cfg_we = we; cfg_ch = ch; cfg_div = dv; cfg_mode = md;
  endtask

  task automatic cyc();
    @(posedge clkin);
    @(negedge clkin);
  endtask

  // Run until tick[ch] is seen; n is the number of edges it took (0 = timeout).
  task automatic wait_tick(input int ch, input int limit, output int n);
    n = 0;
    for (int k = 1; k <= limit; k++) begin
      cyc();
      if (tick[ch]) begin
        n = k;
        break;
      end
    end
    if (n == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_tick_ch%0d: no tick within %0d cycles", ch, limit);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [NCH-1:0] en;
    logic [NCH-1:0] clr;
    logic           we;
    logic [3:0]     ch;
    logic [CW-1:0]  dv;
    logic           md;
    logic [NCH-1:0] exp_clk;
    logic [NCH-1:0] exp_tick;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int n;
    // ch0 counts from reset with divisor 4 (TOGGLE); ch1 gets PULSE/3 while
    // frozen, then starts one edge later.
    tbl[0] = '{4'b0001, 4'b0000, 1'b1, 4'd1, 16'd3, 1'b1, 4'b0000, 4'b0000};
    tbl[1] = '{4'b0011, 4'b0000, 1'b0, 4'd0, 16'd0, 1'b0, 4'b0000, 4'b0000};
    tbl[2] = '{4'b0011, 4'b0000, 1'b0, 4'd0, 16'd0, 1'b0, 4'b0000, 4'b0000};
    tbl[3] = '{4'b0011, 4'b0000, 1'b0, 4'd0, 16'd0, 1'b0, 4'b0011, 4'b0011};
    tbl[4] = '{4'b0011, 4'b0000, 1'b0, 4'd0, 16'd0, 1'b0, 4'b0001, 4'b0000};
    tbl[5] = '{4'b0011, 4'b0000, 1'b0, 4'd0, 16'd0, 1'b0, 4'b0001, 4'b0000};
    tbl[6] = '{4'b0011, 4'b0000, 1'b0, 4'd0, 16'd0, 1'b0, 4'b0011, 4'b0010};
    tbl[7] = '{4'b0011, 4'b0000, 1'b0, 4'd0, 16'd0, 1'b0, 4'b0000, 4'b0001};
    tbl[8] = '{4'b0011, 4'b0000, 1'b0, 4'd0, 16'd0, 1'b0, 4'b0000, 4'b0000};
    tbl[9] = '{4'b0011, 4'b0000, 1'b0, 4'd0, 16'd0, 1'b0, 4'b0010, 4'b0010};

    // reset
    rst = 1'b0;
    drive('0, '0, 1'b0, 4'd0, '0, 1'b0);
    repeat (2) cyc();
    chk("reset_clkout", {28'd0, clkout}, 32'd0);
    chk("reset_tick", {28'd0, tick}, 32'd0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].clr, tbl[i].we, tbl[i].ch, tbl[i].dv, tbl[i].md);
      cyc();
      chk($sformatf("tbl%0d_clkout", i), {28'd0, clkout}, {28'd0, tbl[i].exp_clk});
      chk($sformatf("tbl%0d_tick", i), {28'd0, tick}, {28'd0, tbl[i].exp_tick});
    end

    // ch2: divisor 10, rewritten to 2 when the count reaches 5
    drive(4'b0000, 4'b0000, 1'b1, 4'd2, 16'd10, 1'b0); cyc();
    drive(4'b0000, 4'b0100, 1'b0, 4'd0, 16'd0, 1'b0); cyc();
    drive(4'b0100, 4'b0000, 1'b0, 4'd0, 16'd0, 1'b0);
    repeat (5) cyc();
    chk("ch2_midhalf_clkout", 32'(clkout[2]), 32'd0);
    drive(4'b0100, 4'b0000, 1'b1, 4'd2, 16'd2, 1'b0); cyc();
    drive(4'b0100, 4'b0000, 1'b0, 4'd0, 16'd0, 1'b0);
    wait_tick(2, 40, n);
    chk("ch2_old_half_done", 32'(n), 32'd4);
    chk("ch2_clkout_hi", 32'(clkout[2]), 32'd1);
    wait_tick(2, 40, n);
    chk("ch2_new_half_1", 32'(n), 32'd2);
    chk("ch2_clkout_lo", 32'(clkout[2]), 32'd0);
    wait_tick(2, 40, n);
    chk("ch2_new_half_2", 32'(n), 32'd2);
    chk("ch2_clkout_hi2", 32'(clkout[2]), 32'd1);

    // ch0: pause for 7 cycles mid-count
    drive(4'b0000, 4'b0001, 1'b0, 4'd0, 16'd0, 1'b0); cyc();
    drive(4'b0001, 4'b0000, 1'b0, 4'd0, 16'd0, 1'b0);
    wait_tick(0, 40, n);
    chk("ch0_first_period", 32'(n), 32'd4);
    chk("ch0_clkout_hi", 32'(clkout[0]), 32'd1);
    repeat (2) cyc();
    drive(4'b0000, 4'b0000, 1'b0, 4'd0, 16'd0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk("ch0_paused_clkout", 32'(clkout[0]), 32'd1);
      chk("ch0_paused_tick", 32'(tick[0]), 32'd0);
    end
    drive(4'b0001, 4'b0000, 1'b0, 4'd0, 16'd0, 1'b0);
    wait_tick(0, 40, n);
    chk("ch0_resume_rest", 32'(n), 32'd2);
    chk("ch0_clkout_lo", 32'(clkout[0]), 32'd0);

    // write to a nonexistent channel must not reach any channel
    drive(4'b0000, 4'b0000, 1'b1, 4'd4, 16'd1, 1'b1); cyc();
    drive(4'b0000, 4'b0001, 1'b0, 4'd0, 16'd0, 1'b0); cyc();
    drive(4'b0001, 4'b0000, 1'b0, 4'd0, 16'd0, 1'b0);
    wait_tick(0, 40, n);
    chk("bad_ch_ignored", 32'(n), 32'd4);

    // ch3: clear on the very edge that would be a boundary
    drive(4'b0000, 4'b1000, 1'b0, 4'd0, 16'd0, 1'b0); cyc();
    drive(4'b1000, 4'b0000, 1'b0, 4'd0, 16'd0, 1'b0);
    wait_tick(3, 40, n);
    chk("ch3_period", 32'(n), 32'd4);
    chk("ch3_clkout_hi", 32'(clkout[3]), 32'd1);
    repeat (3) cyc();
    drive(4'b1000, 4'b1000, 1'b0, 4'd0, 16'd0, 1'b0); cyc();
    chk("ch3_clr_clkout", 32'(clkout[3]), 32'd0);
    chk("ch3_clr_tick", 32'(tick[3]), 32'd0);
    drive(4'b1000, 4'b0000, 1'b0, 4'd0, 16'd0, 1'b0);
    wait_tick(3, 40, n);
    chk("ch3_restart_from_0", 32'(n), 32'd4);

    // ch1: divisor 0 freezes at 0; divisor 1 toggles every cycle
    drive(4'b0000, 4'b0000, 1'b1, 4'd1, 16'd0, 1'b0); cyc();
    drive(4'b0010, 4'b0000, 1'b0, 4'd0, 16'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("ch1_div0_clkout", 32'(clkout[1]), 32'd0);
      chk("ch1_div0_tick", 32'(tick[1]), 32'd0);
    end
    drive(4'b0010, 4'b0000, 1'b1, 4'd1, 16'd1, 1'b0); cyc();
    chk("ch1_div1_load", 32'(clkout[1]), 32'd0);
    drive(4'b0010, 4'b0000, 1'b0, 4'd0, 16'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("ch1_div1_clkout", 32'(clkout[1]), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("ch1_div1_tick", 32'(tick[1]), 32'd1);
    end

    // randomized traffic, checked every cycle by the model
    for (int k = 0; k < 3000; k++) begin
      logic [NCH-1:0] en, cl;
      for (int b = 0; b < NCH; b++) begin
        en[b] = ($urandom_range(0, 7) != 0);
        cl[b] = ($urandom_range(0, 39) == 0);
      end
      rst = ($urandom_range(0, 399) != 0);
      drive(en, cl, ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 5)),
            CW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      cyc();
    end
    rst = 1'b1;
    drive('0, '0, 1'b0, 4'd0, '0, 1'b0);
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clkdiv_array.md
CLKDIV_ARRAY -- requirements
Module: clkdiv_array

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent divider channels, range 1..16.
REQ-002 SHALL have parameter CW, default 32: counter/divisor width.
REQ-003 SHALL have parameter DEF_DIV, default 25000: reset divisor of every channel (50 MHz clkin, 1 kHz clkout).
REQ-004 SHALL have port clkin, input, 1: clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port clken, input, NCH: per-channel count enable.
REQ-007 SHALL have port ch_clr, input, NCH: per-channel synchronous clear.
REQ-008 SHALL have port cfg_we, input, 1: config write strobe.
REQ-009 SHALL have port cfg_ch, input, 4: target channel of the write.
REQ-010 SHALL have port cfg_div, input, CW: new divisor.
REQ-011 SHALL have port cfg_mode, input, 1: new mode; 0 = TOGGLE, 1 = PULSE.
REQ-012 SHALL have port clkout, output, NCH: divided clock per channel, registered.
REQ-013 SHALL have port tick, output, NCH: one-cycle strobe on each period boundary, registered.

Function
REQ-014 Each channel SHALL hold active div/mode, pending div/mode, a pending-valid flag, and a CW-bit counter.
REQ-015 With clken[i]=1 and active div>0, counter SHALL increment each cycle; when counter == div-1 it SHALL wrap to 0 in the same edge ("boundary").
REQ-016 TOGGLE mode: clkout[i] SHALL invert at each boundary, giving period 2*div cycles at 50% duty.
REQ-017 PULSE mode: clkout[i] SHALL be 1 only in the cycle after a boundary, giving period div cycles.
REQ-018 tick[i] SHALL be 1 for exactly the cycle after each boundary, in both modes.
REQ-019 div=1 SHALL produce a boundary every enabled cycle: TOGGLE gives clkin/2, PULSE holds clkout constantly 1.
REQ-020 div=0 SHALL freeze the channel: counter, clkout and tick hold 0, with no boundaries.
REQ-021 clken[i]=0 SHALL freeze counter and clkout[i] at their current values, and tick[i] SHALL be 0.
REQ-022 cfg_we with cfg_ch<NCH SHALL load the pending div/mode and set pending-valid; cfg_ch>=NCH SHALL be ignored.
REQ-023 A pending config SHALL become active at the next boundary, with no clkout glitch or runt period.
REQ-024 A pending config SHALL also become active immediately when the channel is frozen (clken=0, or active div=0).
REQ-025 cfg_we coincident with a boundary on the same channel SHALL apply the new values from the following period; the boundary completes with the old values.
REQ-026 Consecutive writes before activation SHALL leave only the last write pending.
REQ-027 ch_clr[i] SHALL zero counter, clkout[i] and tick[i] next cycle; it SHALL apply any pending config and take priority over clken and boundary.
REQ-028 Channels SHALL be fully independent; there SHALL be no cross-channel phase relation except after simultaneous ch_clr.

Reset
REQ-029 rst=0 at an edge SHALL set all counters=0, clkout=0, tick=0, active div=DEF_DIV, mode=TOGGLE, and pending-valid=0.
REQ-030 Reset mid-period SHALL discard partial counts and pending writes; counting SHALL resume on the first edge with rst=1.

Structure
REQ-031 Package clkdiv_pkg SHALL hold the mode enum (MODE_TOGGLE, MODE_PULSE) and the DEF_DIV default.
REQ-032 One sub-module, clkdiv_chan, SHALL implement a single channel; clkdiv_array SHALL generate NCH instances and decode cfg_ch.

Verification
REQ-033 Reset, then clken=1 on ch0 with DEF_DIV reduced to 4 -> clkout[0] toggles every 4 cycles (period 8); tick[0] pulses every 4 cycles.
REQ-034 ch1 PULSE, div=3 -> clkout[1] high 1 of every 3 cycles, identical to tick[1].
REQ-035 ch2 div=10; write div=2 at counter=5 -> current half-period completes at 10 cycles, then half-periods of 2.
REQ-036 clken[0] deasserted for 7 cycles mid-count -> clkout and count hold; period extends by exactly 7.
REQ-037 cfg_we with cfg_ch=NCH -> no channel changes; ch_clr[3] asserted together with a boundary -> clkout[3]=0, tick[3]=0, counter=0.
REQ-038 div=0 written to a disabled channel -> clkout stays 0 after re-enabling; then write div=1 -> clkout toggles every cycle.
